// File: rtl/calc_pkg.sv
// Shared calculator key-event definitions: opcodes, keypad FSM states and matrix map constants.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  localparam logic [2:0] OPROW = 3'd4;
  localparam logic [1:0] EQCOL = 2'd3;

  localparam int unsigned NUM_ROWS = 5;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    DEB  = 2'd1,
    FIRE = 2'd2,
    HOLD = 2'd3
  } key_state_e;

  // Lowest-index active-low row; only meaningful when at least one row is low.
  function automatic logic [2:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_decoder_if.sv
// Calculator key-event interface: the keypad decoder drives it, the Registers block consumes it.
interface keypad_decoder_if;
  logic       newhex;
  logic [3:0] hexcode;
  logic       newop;
  logic [1:0] opcode;
  logic       eq;
  logic       BS;

  modport master (output newhex, hexcode, newop, opcode, eq, BS);
  modport slave  (input  newhex, hexcode, newop, opcode, eq, BS);
endinterface

// File: rtl/key_debounce.sv
// Single-button synchroniser + stable-count debouncer with a one-cycle pulse on the debounced rise.
// KEYPAD_AUTOREPEAT_EN: the pulse also repeats every REPEAT_CYC cycles while the button stays held.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 20000
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_CYC = 500000
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYC + 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  // Level flips only after DEBOUNCE_CYC consecutive samples disagreeing with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      level_d = s2_q;
      cnt_d   = '0;
      rise_d  = s2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d = '0;
    if (level_q && s2_q) begin
      if (rep_q == REP_W'(REPEAT_CYC - 1)) rise_d = 1'b1;
      else                                 rep_d  = rep_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/keypad_decoder.sv
// Scans a 4x5 key matrix plus a backspace button and emits debounced one-cycle key-event pulses.
// KEYPAD_AUTOREPEAT_EN: held hex keys and backspace repeat every REPEAT_CYC cycles.
module keypad_decoder
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 20000
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int unsigned REPEAT_CYC = 500000
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] row_n,
  input  logic                bs_btn,
  output logic [3:0]          col_n,
  keypad_decoder_if.master    kif
);
  localparam int unsigned SLOT_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC);

  key_state_e          state_q, state_d;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic [1:0]          col_q, col_d;
  logic [3:0]          col_n_q, col_n_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          row_q, row_d;
  logic                newhex_q, newhex_d, newop_q, newop_d, eq_q, eq_d;
  logic [3:0]          hexcode_q, hexcode_d;
  logic [1:0]          opcode_q, opcode_d;
  logic                bs_q, bs_d, bs_pend_q, bs_pend_d;
  logic                bs_rise, row_low, col_quiet;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_W = $clog2(REPEAT_CYC + 1);
  logic [REP_W-1:0] rep_q, rep_d;
`endif

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
`ifdef KEYPAD_AUTOREPEAT_EN
    , .REPEAT_CYC(REPEAT_CYC)
`endif
  ) u_bs_debounce (
    .clock(clock),
    .reset(reset),
    .din  (bs_btn),
    .rise (bs_rise)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    newhex_d  = 1'b0;
    newop_d   = 1'b0;
    eq_d      = 1'b0;
    hexcode_d = hexcode_q;
    opcode_d  = opcode_q;
    bs_d      = 1'b0;
    bs_pend_d = 1'b0;
    row_low   = ~row_s2_q[row_q];
    col_quiet = &row_s2_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d     = rep_q;
`endif

    unique case (state_q)
      SCAN: begin
        if (slot_q == SLOT_W'(SCAN_DIV - 1)) begin
          slot_d = '0;
          if (!col_quiet) begin
            row_d   = lowest_low_row(row_s2_q);
            cnt_d   = '0;
            state_d = DEB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      DEB: begin
        if (!row_low) begin
          state_d = SCAN;
          slot_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
          state_d = FIRE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        state_d = HOLD;
        cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = REP_W'(1);
`endif
        if (row_q != OPROW) begin
          newhex_d  = 1'b1;
          hexcode_d = {row_q[1:0], col_q};
        end else if (col_q == EQCOL) begin
          eq_d = 1'b1;
        end else begin
          newop_d = 1'b1;
          unique case (col_q)
            2'd0:    opcode_d = OP_ADD;
            2'd1:    opcode_d = OP_SUB;
            default: opcode_d = OP_MUL;
          endcase
        end
      end
      HOLD: begin
        // Release waits for the whole frozen column, so a second key held here never fires on its own.
        if (!col_quiet) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
          state_d = SCAN;
          slot_d  = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        if (row_low && (row_q != OPROW)) begin
          if (rep_q == REP_W'(REPEAT_CYC - 1)) state_d = FIRE;
          else                                 rep_d   = rep_q + 1'b1;
        end else begin
          rep_d = '0;
        end
`endif
      end
      default: state_d = SCAN;
    endcase

    // A backspace edge that lands on a keypad FIRE cycle is deferred by one cycle.
    if (state_q == FIRE) bs_pend_d = bs_pend_q | bs_rise;
    else                 bs_d      = bs_pend_q | bs_rise;

    col_n_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SCAN;
      row_s1_q  <= '1;
      row_s2_q  <= '1;
      col_q     <= 2'd0;
      col_n_q   <= 4'b1110;
      slot_q    <= '0;
      cnt_q     <= '0;
      row_q     <= 3'd0;
      newhex_q  <= 1'b0;
      newop_q   <= 1'b0;
      eq_q      <= 1'b0;
      hexcode_q <= 4'd0;
      opcode_q  <= 2'd0;
      bs_q      <= 1'b0;
      bs_pend_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_s1_q  <= row_n;
      row_s2_q  <= row_s1_q;
      col_q     <= col_d;
      col_n_q   <= col_n_d;
      slot_q    <= slot_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      newhex_q  <= newhex_d;
      newop_q   <= newop_d;
      eq_q      <= eq_d;
      hexcode_q <= hexcode_d;
      opcode_q  <= opcode_d;
      bs_q      <= bs_d;
      bs_pend_q <= bs_pend_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign col_n       = col_n_q;
  assign kif.newhex  = newhex_q;
  assign kif.hexcode = hexcode_q;
  assign kif.newop   = newop_q;
  assign kif.opcode  = opcode_q;
  assign kif.eq      = eq_q;
  assign kif.BS      = bs_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// Self-checking bench for keypad_decoder: matrix model, event log and key-map reference model.
module tb_keypad_decoder;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int REP      = 40;
  localparam int K_HEX = 0, K_OP = 1, K_EQ = 2, K_BS = 3;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } evt_t;

  logic             clock  = 1'b0;
  logic             reset  = 1'b1;
  logic             bs_btn = 1'b0;
  logic [4:0]       row_n;
  logic [3:0]       col_n;
  logic [4:0][3:0]  keys   = '0;

  evt_t evq[$];
  int   cyc        = 0;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   multi_cnt  = 0;
  int   badcol_cnt = 0;

  keypad_decoder_if kif ();

  keypad_decoder #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CYC(DEB)
`ifdef KEYPAD_AUTOREPEAT_EN
    , .REPEAT_CYC(REP)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .row_n (row_n),
    .bs_btn(bs_btn),
    .col_n (col_n),
    .kif   (kif)
  );

  always #5 clock = ~clock;

  // A closed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference key map straight from the matrix legend.
  function automatic void key_evt(input int r, input int c, output int kind, output int val);
    if (r < 4) begin kind = K_HEX; val = r * 4 + c; end
    else if (c == 3) begin kind = K_EQ; val = 0; end
    else begin kind = K_OP; val = c; end
  endfunction

  task automatic tick();
    int n;
    @(negedge clock);
    cyc++;
    n = 0;
    if (kif.newhex === 1'b1) begin evq.push_back('{cyc, K_HEX, int'(kif.hexcode)}); n++; end
    if (kif.newop  === 1'b1) begin evq.push_back('{cyc, K_OP,  int'(kif.opcode)});  n++; end
    if (kif.eq     === 1'b1) begin evq.push_back('{cyc, K_EQ,  0});                  n++; end
    if (kif.BS     === 1'b1) begin evq.push_back('{cyc, K_BS,  0});                  n++; end
    if (n > 1) multi_cnt++;
    if (!reset && $countones(~col_n) != 1) badcol_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    evq.delete();
  endtask

  task automatic wait_col_start(input int c);
    logic [3:0] tgt, prev;
    bit found;
    tgt   = ~(4'b0001 << c);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = col_n;
      tick();
      if (col_n == tgt && prev != tgt) found = 1'b1;
    end
    check("col_start", found, 1);
  endtask

  task automatic press(input int r, input int c, input int hold, input int gap);
    keys[r][c] = 1'b1;
    ticks(hold);
    keys[r][c] = 1'b0;
    ticks(gap);
  endtask

  task automatic expect_key(input string tag, input int r, input int c);
    int kind, val;
    key_evt(r, c, kind, val);
    check({tag, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      check({tag, "_kind"}, evq[0].kind, kind);
      check({tag, "_val"},  evq[0].val,  val);
    end
  endtask

  task automatic count_kind(input int kind, output int n, output int first_cyc);
    n = 0;
    first_cyc = -1;
    foreach (evq[i]) if (evq[i].kind == kind) begin
      if (n == 0) first_cyc = evq[i].cyc;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_press, n, fc, diff[9], n_hex, n_bs, c_hex, c_bs, kind, val, r, c, hold, bs_off;
    bit use_bs, seen;

    // Reset values
    ticks(2);
    check("rst_col_n",   col_n,       4'b1110);
    check("rst_hexcode", kif.hexcode, 0);
    check("rst_opcode",  kif.opcode,  0);
    check("rst_newhex",  kif.newhex,  0);
    check("rst_newop",   kif.newop,   0);
    check("rst_eq",      kif.eq,      0);
    check("rst_bs",      kif.BS,      0);
    reset = 1'b0;

    // 1: single hex key, exact latency from a slot-aligned press
    wait_col_start(2);
    evq.delete();
    t_press = cyc;
`ifdef KEYPAD_AUTOREPEAT_EN
    press(1, 2, 45, 40);
`else
    press(1, 2, 60, 40);
`endif
    expect_key("t1", 1, 2);
    if (evq.size() > 0) check("t1_latency", evq[0].cyc - t_press, SCAN_DIV + DEB + 1);
    check("t1_hexcode_held", kif.hexcode, 4'h6);

    // 2: operator then equals; opcode and hexcode hold their values
    evq.delete();
    press(4, 1, 45, 30);
    expect_key("t2_sub", 4, 1);
    check("t2_opcode", kif.opcode, 2'b01);
    evq.delete();
    press(4, 3, 45, 30);
    expect_key("t2_eq", 4, 3);
    check("t2_opcode_kept", kif.opcode, 2'b01);
    check("t2_hexcode_kept", kif.hexcode, 4'h6);

    // 3: bouncing contact then stable low
    wait_col_start(1);
    evq.delete();
    for (int k = 0; k < 6; k++) begin
      keys[3][1] = 1'b1; ticks(3);
      keys[3][1] = 1'b0; ticks(1);
    end
    t_press = cyc;
    press(3, 1, 45, 30);
    expect_key("t3", 3, 1);
    if (evq.size() > 0) check("t3_min_latency", (evq[0].cyc - t_press) >= DEB + 3, 1);

    // 4: two keys in one column, lowest row wins, second key never fires by itself
    evq.delete();
    keys[0][0] = 1'b1; keys[2][0] = 1'b1;
    ticks(45);
    expect_key("t4_first", 0, 0);
    evq.delete();
    keys[0][0] = 1'b0; ticks(60);
    keys[2][0] = 1'b0; ticks(30);
    check("t4_no_orphan", evq.size(), 0);
    press(2, 0, 45, 30);
    expect_key("t4_repress", 2, 0);

    // 5: backspace edge swept across the keypad FIRE cycle
    for (int o = 0; o < 9; o++) begin
      do_reset();
      wait_col_start(1);
      evq.delete();
      keys[0][1] = 1'b1;
      for (int t = 0; t < 90; t++) begin
        if (t == o)      bs_btn = 1'b1;
        if (t == o + 40) bs_btn = 1'b0;
        if (t == 40)     keys[0][1] = 1'b0;
        tick();
      end
      count_kind(K_HEX, n_hex, c_hex);
      count_kind(K_BS,  n_bs,  c_bs);
      check("t5_hex_count", n_hex, 1);
      check("t5_bs_count",  n_bs,  1);
      diff[o] = c_bs - c_hex;
      check("t5_apart", diff[o] != 0, 1);
    end
    seen = 1'b0;
    for (int o = 0; o < 8; o++) if (diff[o] == 1 && diff[o+1] == 1) seen = 1'b1;
    check("t5_bs_deferred", seen, 1);

    // 6: reset while holding a key
    do_reset();
    press(4, 2, 45, 30);
    check("t6_opcode_mul", kif.opcode, 2'b10);
    evq.delete();
    keys[2][2] = 1'b1;
    for (int i = 0; i < 60 && evq.size() == 0; i++) tick();
    check("t6_fired", evq.size(), 1);
    ticks(3);
    reset = 1'b1;
    tick();
    check("t6_col_n",   col_n,       4'b1110);
    check("t6_hexcode", kif.hexcode, 0);
    check("t6_opcode",  kif.opcode,  0);
    check("t6_pulses",  {kif.newhex, kif.newop, kif.eq, kif.BS}, 0);
    tick();
    reset = 1'b0;
    evq.delete();
    ticks(50);
    keys[2][2] = 1'b0;
    ticks(30);
    expect_key("t6_redetect", 2, 2);

    // Long holds: auto-repeat only for hex keys and backspace when enabled
    wait_col_start(2);
    evq.delete();
    press(2, 2, DEB + 4 + 130, 30);
    count_kind(K_HEX, n, fc);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("rep_hex_count", n, 4);
    for (int i = 1; i < evq.size(); i++) check("rep_hex_period", evq[i].cyc - evq[i-1].cyc, REP);
`else
    check("rep_hex_count", n, 1);
`endif
    wait_col_start(0);
    evq.delete();
    press(4, 0, DEB + 4 + 130, 30);
    check("rep_op_count", evq.size(), 1);
    evq.delete();
    bs_btn = 1'b1; ticks(120);
    bs_btn = 1'b0; ticks(30);
    count_kind(K_BS, n, fc);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("rep_bs_count", n, 3);
`else
    check("rep_bs_count", n, 1);
`endif

    // Randomised presses, some with a concurrent backspace
    for (int it = 0; it < 8; it++) begin
      r      = $urandom_range(4, 0);
      c      = $urandom_range(3, 0);
      hold   = $urandom_range(45, 36);
      use_bs = 1'($urandom_range(1, 0));
      bs_off = $urandom_range(20, 0);
      key_evt(r, c, kind, val);
      evq.delete();
      keys[r][c] = 1'b1;
      for (int t = 0; t < hold + 30; t++) begin
        if (use_bs && t == bs_off)      bs_btn = 1'b1;
        if (use_bs && t == bs_off + 25) bs_btn = 1'b0;
        if (t == hold)                  keys[r][c] = 1'b0;
        tick();
      end
      count_kind(kind, n, fc);
      check("rnd_key_count", n, 1);
      check("rnd_total", evq.size(), 1 + int'(use_bs));
      if (kind == K_HEX) check("rnd_hexcode", kif.hexcode, val);
      if (kind == K_OP)  check("rnd_opcode",  kif.opcode,  val);
    end

    check("one_pulse_per_cycle", multi_cnt, 0);
    check("col_n_one_low",       badcol_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
